// File: rtl/store_rmw_pkg.sv
// Shared CPU control definitions: store/load size encodings, store FSM states,
// and the alignment rule used to reject illegal stores.
package store_rmw_pkg;

   typedef enum logic [1:0] {
      SZ_WORD = 2'b00,
      SZ_HALF = 2'b01,
      SZ_BYTE = 2'b10,
      SZ_RSVD = 2'b11
   } size_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      WAIT  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } state_t;

   // Reserved size is treated as a fault alongside real misalignment.
   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lane);
      logic bad;
      case (sz)
         SZ_WORD: bad = (lane != 2'b00);
         SZ_HALF: bad = lane[0];
         SZ_BYTE: bad = 1'b0;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/store_merge.sv
// Little-endian lane merge: inserts the store data into the word read back
// from memory at the byte/half lane selected by the address.
module store_merge
   import store_rmw_pkg::*;
(
   input  logic [31:0] rd,
   input  logic [31:0] data,
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   output logic [31:0] merged
);

   always_comb begin
      merged = rd;
      case (size)
         SZ_HALF: begin
            if (lane[1]) merged[31:16] = data[15:0];
            else         merged[15:0]  = data[15:0];
         end
         SZ_BYTE: begin
            case (lane)
               2'd0:    merged[7:0]   = data[7:0];
               2'd1:    merged[15:8]  = data[7:0];
               2'd2:    merged[23:16] = data[7:0];
               default: merged[31:24] = data[7:0];
            endcase
         end
         default: merged = data;
      endcase
   end

endmodule

// File: rtl/store_rmw.sv
// Store unit: word stores write directly, sub-word stores do a read-modify-write
// of the containing word; misaligned or reserved-size requests report err.
module store_rmw
   import store_rmw_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] b_data,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_wr,
   output logic        busy,
   output logic        done,
   output logic        err
);

   state_t      r_state;
   logic [31:0] r_addr;
   logic [1:0]  r_size;
   logic [31:0] r_data;
   logic [31:0] r_rd;
   logic        r_mem_wr;
   logic        r_busy;
   logic        r_done;
   logic        r_err;
   logic [31:0] w_merged;

   store_merge u_merge (
      .rd     (r_rd),
      .data   (r_data),
      .size   (r_size),
      .lane   (r_addr[1:0]),
      .merged (w_merged)
   );

   // Address and write data are decoded from state plus captured registers
   // so the merge can use rd_q directly rather than a bypass of mem_rdata.
   assign mem_addr  = (r_state == IDLE)  ? '0 : {r_addr[31:2], 2'b00};
   assign mem_wdata = (r_state == WRITE) ? w_merged : '0;
   assign mem_wr    = r_mem_wr;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_addr   <= '0;
         r_size   <= '0;
         r_data   <= '0;
         r_rd     <= '0;
         r_mem_wr <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_mem_wr <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_addr <= addr;
                  r_size <= size;
                  r_data <= b_data;
                  r_busy <= 1'b1;
                  if (is_misaligned(size, addr[1:0])) begin
                     r_state <= ERR;
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                  end else if (size == SZ_WORD) begin
                     r_state  <= WRITE;
                     r_mem_wr <= 1'b1;
                  end else begin
                     r_state <= READ;
                  end
               end
            end
            READ: r_state <= WAIT;
            WAIT: begin
               r_rd     <= mem_rdata;
               r_state  <= WRITE;
               r_mem_wr <= 1'b1;
            end
            WRITE: begin
               r_state <= DONE;
               r_done  <= 1'b1;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/store_rmw.md
STORE_RMW -- requirements
Module: store_rmw

Interface
REQ-001 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1: store request, sampled only in IDLE.
REQ-004 SHALL have port size, input, 2: 00 word (SW), 01 half (SH), 10 byte (SB), 11 reserved.
REQ-005 SHALL have port addr, input, 32: byte address, taken from AluOut.
REQ-006 SHALL have port b_data, input, 32: store data, taken from B(rt).
REQ-007 SHALL have port mem_rdata, input, 32: memory read word, valid one cycle after the address is presented.
REQ-008 SHALL have port mem_addr, output, 32: word-aligned address {addr_q[31:2],2'b00}, 0 in IDLE.
REQ-009 SHALL have port mem_wdata, output, 32: write word.
REQ-010 SHALL have port mem_wr, output, 1: one-cycle memory write strobe.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port err, output, 1: misalignment or reserved size, valid with done.

Function
REQ-014 SHALL capture addr, size and b_data into addr_q, size_q and data_q when start=1 in IDLE; inputs are ignored after capture.
REQ-015 SHALL use states IDLE, READ, WAIT, WRITE, DONE, ERR, and SHALL drive all outputs from state and registers only (Moore).
REQ-016 SHALL go from IDLE on start: to ERR if size=11, or size=00 with addr[1:0]!=0, or size=01 with addr[0]=1; otherwise to WRITE if size=00; otherwise to READ.
REQ-017 SHALL present mem_addr with mem_wr=0 in READ, then advance to WAIT.
REQ-018 SHALL latch mem_rdata into rd_q at the end of WAIT, then advance to WRITE.
REQ-019 SHALL assert mem_wr=1 for exactly one cycle in WRITE, then advance to DONE.
REQ-020 SHALL form mem_wdata in WRITE as follows (little-endian): word = data_q; half = rd_q with bits [16*addr_q[1]+15 : 16*addr_q[1]] replaced by data_q[15:0]; byte = rd_q with bits [8*addr_q[1:0]+7 : 8*addr_q[1:0]] replaced by data_q[7:0].
REQ-021 SHALL pulse done=1 for one cycle in DONE with err=0, then return to IDLE.
REQ-022 SHALL pulse done=1 and err=1 for one cycle in ERR, never assert mem_wr, then return to IDLE.
REQ-023 SHALL have a latency, counted in edges after the start-sampling edge, of 2 until done for a word store, 4 for a sub-word store, and 1 for an error.
REQ-024 SHALL ignore start while busy=1; back-to-back requests are accepted in the cycle after done.
REQ-025 SHALL drive mem_wdata=0 in every state other than WRITE.

Reset
REQ-026 SHALL, with reset=0, asynchronously force state=IDLE, mem_wr=0, done=0, err=0, busy=0, mem_addr=0, mem_wdata=0 and clear addr_q, size_q, data_q and rd_q.
REQ-027 SHALL abort an in-flight operation on reset assertion without any partial write; mem_wr falls in the same cycle.
REQ-028 SHALL sample start no earlier than the first rising edge after reset deassertion.

Structure
REQ-029 SHALL take the size encodings (SZ_WORD, SZ_HALF, SZ_BYTE) and the state encoding from the shared CPU control package, which the load-size unit also uses.
REQ-030 SHALL place the REQ-020 lane merge in one combinational sub-module store_merge (inputs rd, data, size, lane; output merged word).

Verification
REQ-031 SHALL verify an aligned SW: start, size=00, addr=0x0000_0010, b_data=0xDEAD_BEEF -> mem_wr pulse at mem_addr 0x10 with wdata 0xDEAD_BEEF, done 2 edges later, err=0.
REQ-032 SHALL verify SB: addr=0x0000_0013, b_data=0x0000_00AB, mem_rdata=0x1122_3344 -> one READ at 0x10, mem_wdata 0xAB22_3344, done 4 edges later.
REQ-033 SHALL verify SH: addr=0x0000_0012, b_data=0xFFFF_CAFE, mem_rdata=0x1122_3344 -> mem_wdata 0xCAFE_3344.
REQ-034 SHALL verify misaligned stores: SW at addr=0x0000_0006 and SH at addr=0x0000_0011 -> each gives done=1, err=1 after 1 edge, and mem_wr stays 0 throughout.
REQ-035 SHALL verify reset and start handling: reset=0 asserted during WAIT of an SB -> immediate IDLE with all outputs 0 and no mem_wr; a start pulse during busy -> ignored, exactly one write.
REQ-036 SHALL verify back-to-back stores: SB at 0x20 then SW at 0x24 issued the cycle after done -> two writes, two done pulses, correct data each.
